// File: rtl/regs_bank_param.sv
// Parametrised 2R/1W register bank with PC link path and same-edge write bypass.
// Optional build macro ZERO_REG_EN hardwires register 0 to zero.
module regs_bank_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LINK_REG = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] inpA,
  input  logic [ADDR_W-1:0] inpB,
  input  logic [ADDR_W-1:0] inpC,
  input  logic [2:0]        control,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  typedef enum logic [2:0] {
    OP_FULL  = 3'b000,
    OP_LOW   = 3'b001,
    OP_HIGH  = 3'b010,
    OP_LINK  = 3'b011,
    OP_WLINK = 3'b100
  } op_e;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic wr_full;
  logic wr_low;
  logic wr_high;
  logic wr_link;

  always_comb begin
    wr_full = 1'b0;
    wr_low  = 1'b0;
    wr_high = 1'b0;
    wr_link = 1'b0;
    case (control)
      OP_FULL:  wr_full = 1'b1;
      OP_LOW:   wr_low  = 1'b1;
      OP_HIGH:  wr_high = 1'b1;
      OP_LINK:  wr_link = 1'b1;
      OP_WLINK: begin
        wr_full = 1'b1;
        wr_link = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state image doubles as the bypass source: reads index it directly.
  always_comb begin
    regs_d = regs_q;
    unique case (1'b1)
      wr_full: regs_d[inpC] = data;
      wr_low:  regs_d[inpC][HALF_W-1:0] = data[HALF_W-1:0];
      wr_high: regs_d[inpC][DATA_W-1:HALF_W] = data[HALF_W-1:0];
      default: ;
    endcase
    if (wr_link) begin
      regs_d[LINK_IDX] = pc;
    end
`ifdef ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      outA <= '0;
      outB <= '0;
    end else begin
      regs_q <= regs_d;
      outA   <= regs_d[inpA];
      outB   <= regs_d[inpB];
    end
  end

endmodule

// File: tb/tb_regs_bank_param.sv
// Directed scoreboard bench for regs_bank_param.
// Build with ZERO_REG_EN defined to exercise the hardwired-zero register.
module tb_regs_bank_param;

  logic        clk;
  logic        rst_n;
  logic [3:0]  inpA, inpB, inpC;
  logic [2:0]  control;
  logic [31:0] data, pc;
  logic [31:0] outA, outB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb_q[$];

  regs_bank_param #(
    .DATA_W(32),
    .ADDR_W(4),
    .LINK_REG(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inpA(inpA),
    .inpB(inpB),
    .inpC(inpC),
    .control(control),
    .data(data),
    .pc(pc),
    .outA(outA),
    .outB(outB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one registered result per rising edge after a driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".A"}, outA, e.a);
        chk({e.name, ".B"}, outB, e.b);
      end
    end
  end

  task automatic cyc(input string nm, input logic [2:0] ctl,
                     input logic [3:0] c, input logic [31:0] d,
                     input logic [31:0] p, input logic [3:0] a,
                     input logic [3:0] b, input logic [31:0] ea,
                     input logic [31:0] eb);
    exp_t e;
    @(negedge clk);
    control = ctl;
    inpC    = c;
    data    = d;
    pc      = p;
    inpA    = a;
    inpB    = b;
    e.name  = nm;
    e.a     = ea;
    e.b     = eb;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    control = 3'b101;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] z_exp;

  initial begin
`ifdef ZERO_REG_EN
    z_exp = 32'h0;
`else
    z_exp = 32'hFFFF_FFFF;
`endif
    rst_n   = 1'b0;
    control = 3'b101;
    inpA    = 4'd0;
    inpB    = 4'd0;
    inpC    = 4'd0;
    data    = '0;
    pc      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outA", outA, 32'h0);
    chk("rst_outB", outB, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("preload", 3'b000, 4'd3, 32'hDEADBEEF, 0, 4'd3, 4'd3,
        32'hDEADBEEF, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pulse_outA", outA, 32'h0);
    chk("pulse_outB", outB, 32'h0);
    #1;
    rst_n = 1'b1;
    cyc("r3_cleared", 3'b101, 4'd3, 32'h1, 0, 4'd3, 4'd0, 0, 0);

    cyc("full_r5", 3'b000, 4'd5, 32'h55555555, 0, 4'd5, 4'd3,
        32'h55555555, 0);
    cyc("low_r5", 3'b001, 4'd5, 32'hFFFFFFFF, 0, 4'd5, 4'd5,
        32'h5555FFFF, 32'h5555FFFF);
    cyc("high_r5", 3'b010, 4'd5, 32'h0000ABCD, 0, 4'd0, 4'd5,
        0, 32'hABCDFFFF);
    cyc("full_r7", 3'b000, 4'd7, 32'hAAAA0000, 0, 4'd5, 4'd7,
        32'hABCDFFFF, 32'hAAAA0000);
    cyc("byp_low", 3'b001, 4'd7, 32'h12345678, 0, 4'd7, 4'd1,
        32'hAAAA5678, 0);
    cyc("byp_full", 3'b000, 4'd7, 32'h12345678, 0, 4'd7, 4'd5,
        32'h12345678, 32'hABCDFFFF);
    cyc("link", 3'b011, 4'd2, 32'h99, 32'h33333333, 4'd15, 4'd2,
        32'h33333333, 0);
    cyc("wlink_same", 3'b100, 4'd15, 32'h1, 32'h40, 4'd15, 4'd15,
        32'h40, 32'h40);
    cyc("wlink_r2", 3'b100, 4'd2, 32'hCAFEF00D, 32'h77, 4'd2, 4'd15,
        32'hCAFEF00D, 32'h77);
    cyc("nop101", 3'b101, 4'd5, 32'h0, 32'h5, 4'd5, 4'd7,
        32'hABCDFFFF, 32'h12345678);
    cyc("nop110", 3'b110, 4'd7, 32'hFFFFFFFF, 32'h6, 4'd7, 4'd2,
        32'h12345678, 32'hCAFEF00D);
    cyc("nop111", 3'b111, 4'd15, 32'h0, 32'h1, 4'd15, 4'd3,
        32'h77, 0);
    cyc("zero_wr", 3'b000, 4'd0, 32'hFFFFFFFF, 0, 4'd0, 4'd0,
        z_exp, z_exp);
    cyc("zero_rd", 3'b101, 4'd0, 32'h0, 0, 4'd0, 4'd5,
        z_exp, 32'hABCDFFFF);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
